// File: rtl/counter_mon_pkg.sv
// Shared types, default parameters and helpers for the counter sample monitor.
package counter_mon_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_SAMPLE_DIV = 16;
  localparam int DEF_WRAP_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Successor of a counter value of the given width (up to 32 bits), wrapping at 2^width.
  function automatic logic [31:0] next_val(input logic [31:0] prev, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (prev + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/mon_sample_fifo.sv
// Small synchronous sample FIFO. A push into a full FIFO is accepted only when
// a pop happens in the same cycle; the head output holds the last popped value
// while the FIFO is empty.
module mon_sample_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] last_q;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? last_q : mem[rd_ptr[AW-1:0]];

  // Pointer and hold-register update; flush empties the queue but keeps the held value.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Sample storage write; when full with a pop, the slot being vacated is overwritten.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/counter_sample_monitor.sv
// Observation stage for the free-running counter: checks +1 stepping, counts
// wrap-arounds and queues one decimated sample every SAMPLE_DIV running cycles.
module counter_sample_monitor
  import counter_mon_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int WRAP_W     = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cnt_in,
  input  logic              enable,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_skip,
  output logic              err_stuck,
  output logic              overflow
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] expected;
  logic [DIV_W-1:0]  div_q;
  logic              run_cycle;
  logic              div_tc;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              is_stuck;
  logic              is_skip;
  logic              is_wrap;

  // clear overrides everything in its cycle, so a RUN cycle only counts without it.
  assign run_cycle = (state_q == RUN) && !clear;
  assign expected  = DATA_W'(next_val(32'(prev_q), DATA_W));
  assign is_stuck  = (cnt_in == prev_q);
  assign is_skip   = !is_stuck && (cnt_in != expected);
  assign is_wrap   = (prev_q == '1) && (cnt_in == '0);
  assign div_tc    = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign push      = run_cycle && div_tc;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Next-state logic for IDLE -> ARM -> RUN, with clear forcing a re-arm.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = ARM;
      ARM:     state_d = enable ? RUN : IDLE;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = enable ? ARM : IDLE;
  end

  // State, previous-value and sample-divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q != IDLE) && !clear) prev_q <= cnt_in;
      if (run_cycle && (state_d == RUN) && !div_tc) div_q <= div_q + 1'b1;
      else                                          div_q <= '0;
    end
  end

  // Sticky error flags and the saturating wrap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_stuck  <= 1'b0;
      err_skip   <= 1'b0;
      overflow   <= 1'b0;
      wrap_count <= '0;
    end else if (clear) begin
      err_stuck  <= 1'b0;
      err_skip   <= 1'b0;
      overflow   <= 1'b0;
      wrap_count <= '0;
    end else begin
      if (run_cycle && is_stuck) err_stuck <= 1'b1;
      if (run_cycle && is_skip)  err_skip  <= 1'b1;
      if (run_cycle && is_wrap && (wrap_count != '1)) wrap_count <= wrap_count + 1'b1;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  mon_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cnt_in),
    .pop       (pop),
    .flush     (clear),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_data)
  );

endmodule

// File: tb/tb_counter_sample_monitor.sv
// Directed bench for counter_sample_monitor with hand-computed expectations.
module tb_counter_sample_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cnt_in;
  logic        enable;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] wrap_count;
  logic        err_skip;
  logic        err_stuck;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_sample_monitor #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .SAMPLE_DIV (16),
    .WRAP_W     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_in     (cnt_in),
    .enable     (enable),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .wrap_count (wrap_count),
    .err_skip   (err_skip),
    .err_stuck  (err_stuck),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one counter value, take one clock edge, settle 1 time unit after it.
  task automatic tick(input logic [7:0] v);
    cnt_in = v;
    @(posedge clk);
    #1;
  endtask

  // Clear edge (enable=1 -> ARM), then the ARM edge loading arm_val.
  task automatic restart(input logic [7:0] arm_val);
    clear = 1'b1;
    tick(8'hEE);
    clear = 1'b0;
    tick(arm_val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    out_ready = 1'b1;
    cnt_in    = 8'h00;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_wrap", wrap_count, 0);
    check("rst_skip", err_skip, 0);
    check("rst_stuck", err_stuck, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: IDLE edge 0x00, ARM edge 0x01, pushes at 0x11 and 0x21, each popped next edge.
    for (int i = 0; i <= 33; i++) begin
      tick(8'(i));
      check("t1_valid", out_valid, (i == 17 || i == 33) ? 1 : 0);
      if (i == 17) check("t1_data0", out_data, 8'h11);
      if (i == 33) check("t1_data1", out_data, 8'h21);
    end
    check("t1_skip", err_skip, 0);
    check("t1_stuck", err_stuck, 0);
    check("t1_ovf", overflow, 0);

    // 2: keep counting through 0xFF->0x00, then three more full wraps.
    for (int i = 8'h22; i <= 8'hFF; i++) tick(8'(i));
    check("t2_wrap_pre", wrap_count, 0);
    tick(8'h00);
    check("t2_wrap1", wrap_count, 1);
    check("t2_skip", err_skip, 0);
    check("t2_stuck", err_stuck, 0);
    for (int i = 1; i <= 768; i++) tick(8'(i));
    check("t2_wrap4", wrap_count, 4);
    check("t2_skip_end", err_skip, 0);

    // 3: stuck value, then a skip, then clear and re-arm.
    clear = 1'b1;
    tick(8'h77);
    clear = 1'b0;
    check("t3_clr_wrap", wrap_count, 0);
    tick(8'h10);
    tick(8'h11);
    check("t3_stuck_pre", err_stuck, 0);
    tick(8'h11);
    check("t3_stuck", err_stuck, 1);
    check("t3_noskip", err_skip, 0);
    tick(8'h12);
    check("t3_noskip2", err_skip, 0);
    check("t3_stuck_hold", err_stuck, 1);
    restart(8'h20);
    tick(8'h23);
    check("t3_skip", err_skip, 1);
    check("t3_stuck_clr", err_stuck, 0);
    clear = 1'b1;
    tick(8'h24);
    clear = 1'b0;
    check("t3_clr_skip", err_skip, 0);
    check("t3_clr_stuck", err_stuck, 0);
    tick(8'h50);
    check("t3_arm_nochk", err_skip, 0);
    tick(8'h51);
    check("t3_run_skip", err_skip, 0);
    check("t3_run_stuck", err_stuck, 0);

    // 4: consumer stalled for five sample periods; fifth sample (0x50) dropped.
    out_ready = 1'b0;
    restart(8'h00);
    for (int i = 1; i <= 8'h50; i++) begin
      tick(8'(i));
      if (i == 8'h40) check("t4_ovf_pre", overflow, 0);
    end
    check("t4_ovf", overflow, 1);
    check("t4_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("t4_drain_valid", out_valid, 1);
      check("t4_drain_data", out_data, 8'h10 * (j + 1));
      tick(8'(8'h51 + j));
    end
    check("t4_empty", out_valid, 0);
    check("t4_hold", out_data, 8'h40);

    // 5: full FIFO, ready raised exactly for the push edge of 0x50.
    out_ready = 1'b0;
    restart(8'h00);
    for (int i = 1; i <= 8'h4F; i++) tick(8'(i));
    check("t5_full_head", out_data, 8'h10);
    check("t5_ovf_pre", overflow, 0);
    out_ready = 1'b1;
    tick(8'h50);
    check("t5_ovf", overflow, 0);
    for (int j = 0; j < 4; j++) begin
      check("t5_drain_valid", out_valid, 1);
      check("t5_drain_data", out_data, 8'h20 + 8'h10 * j);
      tick(8'(8'h51 + j));
    end
    check("t5_empty", out_valid, 0);

    // 6: asynchronous reset between edges with two entries queued and err_skip set.
    out_ready = 1'b0;
    restart(8'h00);
    for (int i = 1; i <= 8'h20; i++) tick(8'(i));
    tick(8'h30);
    check("t6_skip_pre", err_skip, 1);
    check("t6_valid_pre", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_data", out_data, 0);
    check("t6_skip", err_skip, 0);
    check("t6_wrap", wrap_count, 0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      tick(8'(i));
      check("t6_cap_valid", out_valid, (i == 17) ? 1 : 0);
    end
    check("t6_cap_data", out_data, 8'h11);
    check("t6_skip_end", err_skip, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
